// File: rtl/pool2x2_stream_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared types and helpers for the 2x2 stride-2 streaming pooling engine.
//   pool_mode_e  : per-frame pooling mode (average or max)
//   pool_state_e : row-phase FSM state of the engine
//   smax         : signed maximum; callers sign-extend their operands to
//                  SMAX_W bits and narrow the result back to their own width
// ---------------------------------------------------------------------------
package pool_pkg;

   typedef enum logic {
      POOL_AVG = 1'b0,
      POOL_MAX = 1'b1
   } pool_mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROW_EVEN = 2'd1,
      ROW_ODD  = 2'd2
   } pool_state_e;

   // Wide enough for any partial of a DATA_W <= 32 engine.
   localparam int SMAX_W = 33;

   function automatic logic signed [SMAX_W-1:0] smax(
      input logic signed [SMAX_W-1:0] a,
      input logic signed [SMAX_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool2x2_stream_if.sv
// ---------------------------------------------------------------------------
// pool2x2_stream_if
// Pixel-in / pooled-value-out stream bundle of the pooling engine.
//   in_data/in_valid/in_ready    : raster-order signed pixels (valid/ready)
//   out_data/out_valid/out_ready : pooled values (valid/ready)
//   out_last                     : final pooled value of a frame
// Modports:
//   slave  : the pooling engine
//   master : the environment (pixel producer and result consumer)
// ---------------------------------------------------------------------------
interface pool2x2_stream_if #(
   parameter int DATA_W = 8
);
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/pool2x2_stream_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf
// Half-width line buffer holding the horizontal partials of an even row
// until the matching odd row arrives.
//   clock : write clock
//   we    : write enable
//   idx   : shared write/read index (pixel column / 2)
//   wdata : partial to store
//   rdata : combinational read of entry idx
// Writes happen only in even rows and reads only in odd rows, so the same
// entry is never written and read in one cycle. Contents have no reset.
// ---------------------------------------------------------------------------
module pool_line_buf #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 9,
   parameter int IDX_W = 4
) (
   input  logic                    clock,
   input  logic                    we,
   input  logic        [IDX_W-1:0] idx,
   input  logic signed [WIDTH-1:0] wdata,
   output logic signed [WIDTH-1:0] rdata
);

   logic signed [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem_q[idx] <= wdata;
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/pool2x2_stream.sv
// ---------------------------------------------------------------------------
// pool2x2_stream
// Streaming 2x2 stride-2 pooling engine (average or max, chosen per frame).
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset of all control state
//   mode       : 0 = average, 1 = max; captured with a frame's first pixel
//   st         : stream bundle (slave side): pixels in, pooled values out
//   frame_done : one-cycle pulse when the frame's last result is accepted
// Even rows reduce each horizontal pixel pair into the line buffer; odd rows
// reduce their pair and combine it with the stored partial into one result.
// ---------------------------------------------------------------------------
module pool2x2_stream
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   pool2x2_stream_if.slave   st,
   output logic              frame_done
);

   localparam int COL_W    = $clog2(IMG_W);
   localparam int ROW_W    = $clog2(IMG_H);
   localparam int LB_DEPTH = IMG_W / 2;
   localparam int LB_IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int PW       = DATA_W + 1;   // horizontal partial width
   localparam int SW       = DATA_W + 2;   // four-pixel sum width

   // Floor division by 4; the shifted sum always fits back into DATA_W.
   function automatic logic signed [DATA_W-1:0] avg_floor(
      input logic signed [SW-1:0] s
   );
      return DATA_W'(s >>> 2);
   endfunction

   pool_state_e              state_q, state_d;
   logic        [COL_W-1:0]  col_q, col_d;
   logic        [ROW_W-1:0]  row_q, row_d;
   pool_mode_e               mode_q, mode_d;
   logic signed [DATA_W-1:0] pair_q, pair_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;

   logic                     accept;
   logic                     last_col, last_row, odd_col, odd_row;
   pool_mode_e               eff_mode;
   logic signed [PW-1:0]     h_part;
   logic signed [SW-1:0]     sum4;
   logic signed [DATA_W-1:0] win_res;
   logic                     lb_we;
   logic        [LB_IDX_W-1:0] lb_idx;
   logic signed [PW-1:0]     lb_rdata;

   assign st.in_ready = !out_valid_q || st.out_ready;
   assign accept      = st.in_valid && st.in_ready;
   assign last_col    = (col_q == COL_W'(IMG_W - 1));
   assign last_row    = (row_q == ROW_W'(IMG_H - 1));
   assign odd_col     = col_q[0];
   assign odd_row     = (state_q == ROW_ODD);
   // The first pixel of a frame already uses the mode being latched with it.
   assign eff_mode    = (state_q == IDLE) ? pool_mode_e'(mode) : mode_q;
   assign lb_idx      = LB_IDX_W'(col_q >> 1);
   assign lb_we       = accept && !odd_row && odd_col;

   always_comb begin
      if (eff_mode == POOL_AVG) begin
         h_part = PW'(pair_q) + PW'(st.in_data);
      end else begin
         h_part = PW'(smax(SMAX_W'(pair_q), SMAX_W'(st.in_data)));
      end
      sum4 = SW'(lb_rdata) + SW'(h_part);
      if (eff_mode == POOL_AVG) begin
         win_res = avg_floor(sum4);
      end else begin
         win_res = DATA_W'(smax(SMAX_W'(lb_rdata), SMAX_W'(h_part)));
      end
   end

   pool_line_buf #(
      .DEPTH (LB_DEPTH),
      .WIDTH (PW),
      .IDX_W (LB_IDX_W)
   ) u_line_buf (
      .clock (clock),
      .we    (lb_we),
      .idx   (lb_idx),
      .wdata (h_part),
      .rdata (lb_rdata)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      mode_d      = mode_q;
      pair_d      = pair_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (out_valid_q && st.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (accept) begin
         if (!odd_col) pair_d = st.in_data;

         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end

         case (state_q)
            IDLE: begin
               mode_d  = pool_mode_e'(mode);
               state_d = ROW_EVEN;
            end
            ROW_EVEN: begin
               if (last_col) state_d = ROW_ODD;
            end
            ROW_ODD: begin
               if (last_col) state_d = last_row ? IDLE : ROW_EVEN;
            end
            default: state_d = IDLE;
         endcase

         // Accept implies the output register is empty or draining now.
         if (odd_row && odd_col) begin
            out_valid_d = 1'b1;
            out_data_d  = win_res;
            out_last_d  = last_row && last_col;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= POOL_AVG;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Pixel pair holder: pure data, always rewritten before use.
   always_ff @(posedge clock) begin
      pair_q <= pair_d;
   end

   assign st.out_data  = out_data_q;
   assign st.out_valid = out_valid_q;
   assign st.out_last  = out_last_q;
   assign frame_done   = out_valid_q && st.out_ready && out_last_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench: three engines (4x4, 2x2, 28x28) share clock, reset,
// mode and pixel data; each has its own valid/ready. Only one engine is
// streamed at a time, so a single expected-value queue serves all three.
module tb_pool2x2_stream;
   import pool_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic mode  = 1'b0;
   always #5 clock = ~clock;

   logic signed [7:0] px;
   logic [2:0] iv;
   logic [2:0] ordy;
   logic       rnd_rdy;
   logic       rr;
   wire  [2:0] rdy_w = {rnd_rdy ? rr : ordy[2], ordy[1:0]};
   wire  [2:0] irdy, ov, ol, fd;
   wire  signed [7:0] od [3];

   pool2x2_stream_if #(.DATA_W(8)) if_a ();
   pool2x2_stream_if #(.DATA_W(8)) if_b ();
   pool2x2_stream_if #(.DATA_W(8)) if_c ();

   assign if_a.in_data = px; assign if_a.in_valid = iv[0]; assign if_a.out_ready = rdy_w[0];
   assign if_b.in_data = px; assign if_b.in_valid = iv[1]; assign if_b.out_ready = rdy_w[1];
   assign if_c.in_data = px; assign if_c.in_valid = iv[2]; assign if_c.out_ready = rdy_w[2];
   assign irdy = {if_c.in_ready,  if_b.in_ready,  if_a.in_ready};
   assign ov   = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
   assign ol   = {if_c.out_last,  if_b.out_last,  if_a.out_last};
   assign od[0] = if_a.out_data;
   assign od[1] = if_b.out_data;
   assign od[2] = if_c.out_data;

   pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
      .clock(clock), .reset(reset), .mode(mode), .st(if_a), .frame_done(fd[0]));
   pool2x2_stream #(.DATA_W(8), .IMG_W(2), .IMG_H(2)) u_dut2 (
      .clock(clock), .reset(reset), .mode(mode), .st(if_b), .frame_done(fd[1]));
   pool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28)) u_dut28 (
      .clock(clock), .reset(reset), .mode(mode), .st(if_c), .frame_done(fd[2]));

   typedef struct {
      int                k;
      logic signed [7:0] d;
      logic              last;
   } exp_t;

   exp_t sbq[$];
   int   errs = 0;
   int   checks = 0;
   int   fd_cnt[3] = '{0, 0, 0};
   int   out_cnt[3] = '{0, 0, 0};
   int   cyc = 0;
   int   frm[28*28];

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clock); #1;
         rr = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input int k, input int d, input logic last);
      exp_t e;
      e.k = k; e.d = 8'(d); e.last = last;
      sbq.push_back(e);
   endtask

   function automatic logic signed [7:0] ref_pool(input int a, input int b,
                                                   input int c, input int d,
                                                   input logic m);
      int s;
      if (!m) begin
         s = (a + b + c + d) >>> 2;
      end else begin
         s = a;
         if (b > s) s = b;
         if (c > s) s = c;
         if (d > s) s = d;
      end
      return 8'(s);
   endfunction

   // Monitor: pop and compare on every output handshake.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            if (fd[k]) fd_cnt[k]++;
            if (ov[k] && rdy_w[k]) begin
               out_cnt[k]++;
               if (sbq.size() == 0) begin
                  chk("unexpected_output", k, -1);
               end else begin
                  e = sbq.pop_front();
                  chk("out_source", k, e.k);
                  chk("out_data", int'(od[k]), int'(e.d));
                  chk("out_last", int'(ol[k]), int'(e.last));
               end
            end
         end
      end
   end

   task automatic send_px(input int k, input logic signed [7:0] v);
      bit acc;
      int n;
      px = v; iv[k] = 1'b1; acc = 1'b0; n = 0;
      while (!acc && n < 1000) begin
         @(negedge clock);
         acc = irdy[k];
         @(posedge clock); #1;
         n++;
      end
      if (!acc) chk("in_accept_timeout", 0, 1);
   endtask

   task automatic send_frame(input int k, input int w, input int h, input logic m,
                             input int npix, input bit rnd);
      for (int i = 0; i < npix; i++) begin
         int r, c, g;
         r = i / w; c = i % w;
         if (rnd) begin
            g = $urandom_range(0, 2);
            if (g != 0) begin
               iv[k] = 1'b0;
               repeat (g) begin @(posedge clock); #1; end
            end
         end
         if (i == 0) mode = m;
         else if (rnd) mode = 1'($urandom_range(0, 1));
         if (rnd && (r % 2 == 1) && (c % 2 == 1))
            push(k, int'(ref_pool(frm[(r-1)*w+c-1], frm[(r-1)*w+c], frm[r*w+c-1], frm[r*w+c], m)),
                 (r == h-1) && (c == w-1));
         send_px(k, 8'(frm[i]));
      end
   endtask

   task automatic stall_check(input int k, input int held);
      int n;
      n = 0;
      while (!ov[k] && n < 1000) begin @(posedge clock); #1; n++; end
      chk("stall_first_output", int'(ov[k]), 1);
      ordy[k] = 1'b0;
      repeat (5) begin
         @(negedge clock);
         chk("stall_in_ready", int'(irdy[k]), 0);
         chk("stall_out_valid", int'(ov[k]), 1);
         chk("stall_out_data", int'(od[k]), held);
         @(posedge clock); #1;
      end
      ordy[k] = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 5000) begin @(posedge clock); #1; n++; end
      repeat (3) begin @(posedge clock); #1; end
      chk("drain_queue_empty", sbq.size(), 0);
   endtask

   task automatic fill4x4();
      for (int i = 0; i < 16; i++) frm[i] = i + 1;
   endtask

   task automatic fill2x2(input int a, input int b, input int c, input int d);
      frm[0] = a; frm[1] = b; frm[2] = c; frm[3] = d;
   endtask

   initial begin
      int c0;
      iv = '0; ordy = 3'b111; rnd_rdy = 1'b0; px = '0; mode = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_valid", int'(ov[0]), 0);
      chk("rst_out_last", int'(ol[0]), 0);
      chk("rst_out_data", int'(od[0]), 0);
      chk("rst_frame_done", int'(fd[0]), 0);
      chk("rst_in_ready", int'(irdy[0]), 1);
      chk("rst_out_valid_28", int'(ov[2]), 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // 4x4 AVG then MAX, back to back with no gap
      fill4x4();
      push(0, 3, 0); push(0, 5, 0); push(0, 11, 0); push(0, 13, 1);
      push(0, 6, 0); push(0, 8, 0); push(0, 14, 0); push(0, 16, 1);
      c0 = cyc;
      send_frame(0, 4, 4, 1'b0, 16, 1'b0);
      send_frame(0, 4, 4, 1'b1, 16, 1'b0);
      chk("b2b_cycles", cyc - c0, 32);
      iv[0] = 1'b0;
      drain();
      chk("fd_after_b2b", fd_cnt[0], 2);

      // backpressure on the first output
      push(0, 3, 0); push(0, 5, 0); push(0, 11, 0); push(0, 13, 1);
      fork
         send_frame(0, 4, 4, 1'b0, 16, 1'b0);
         stall_check(0, 3);
      join
      iv[0] = 1'b0;
      drain();

      // reset after 10 pixels, then a full frame
      push(0, 3, 0); push(0, 5, 0);
      send_frame(0, 4, 4, 1'b0, 10, 1'b0);
      iv[0] = 1'b0;
      drain();
      reset = 1'b1; #1;
      chk("midrst_out_valid", int'(ov[0]), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      push(0, 3, 0); push(0, 5, 0); push(0, 11, 0); push(0, 13, 1);
      send_frame(0, 4, 4, 1'b0, 16, 1'b0);
      iv[0] = 1'b0;
      drain();
      chk("fd_count_4x4", fd_cnt[0], 4);
      chk("out_count_4x4", out_cnt[0], 18);

      // 2x2 negative floor and extremes, back to back
      fill2x2(-1, -1, -1, -2);     push(1, -2, 1);  send_frame(1, 2, 2, 1'b0, 4, 1'b0);
      fill2x2(127, 127, 127, 127); push(1, 127, 1); send_frame(1, 2, 2, 1'b0, 4, 1'b0);
      fill2x2(-128, -128, -128, -128); push(1, -128, 1); send_frame(1, 2, 2, 1'b0, 4, 1'b0);
      fill2x2(-128, 127, 0, 5);    push(1, 127, 1); send_frame(1, 2, 2, 1'b1, 4, 1'b0);
      fill2x2(-7, -3, -128, -9);   push(1, -3, 1);  send_frame(1, 2, 2, 1'b1, 4, 1'b0);
      iv[1] = 1'b0;
      drain();
      chk("fd_count_2x2", fd_cnt[1], 5);

      // reset while a result is pending drops out_valid at once
      ordy[1] = 1'b0;
      fill2x2(1, 2, 3, 4);
      send_frame(1, 2, 2, 1'b0, 4, 1'b0);
      iv[1] = 1'b0;
      @(posedge clock); #1;
      chk("pending_out_valid", int'(ov[1]), 1);
      chk("pending_out_data", int'(od[1]), 2);
      reset = 1'b1; #1;
      chk("async_rst_out_valid", int'(ov[1]), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      ordy[1] = 1'b1;
      @(posedge clock); #1;
      chk("fd_after_pending_rst", fd_cnt[1], 5);

      // 28x28 random pixels, random gaps/backpressure, mode toggling
      rnd_rdy = 1'b1;
      for (int i = 0; i < 784; i++) frm[i] = int'($urandom_range(0, 255)) - 128;
      frm[0] = -128; frm[1] = -128; frm[28] = -128; frm[29] = -128;
      send_frame(2, 28, 28, 1'b0, 784, 1'b1);
      for (int i = 0; i < 784; i++) frm[i] = int'($urandom_range(0, 255)) - 128;
      frm[54] = 127; frm[55] = 127; frm[82] = 127; frm[83] = 127;
      send_frame(2, 28, 28, 1'b1, 784, 1'b1);
      iv[2] = 1'b0;
      drain();
      rnd_rdy = 1'b0;
      chk("out_count_28", out_cnt[2], 392);
      chk("fd_count_28", fd_cnt[2], 2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
      $fatal(1);
   end

endmodule
